srm_core: RTL

SRM_CORE -- requirements
Module: srm_core

---
 rtl/srm_core.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/srm_core.sv
// Simple RISC multicycle core: 16-bit datapath, 8 registers, single shared memory port.
// The controller steps through FETCH/DECODE/LOADA/LOADB/EXEC/WRITE/ADDR/MEM/HALT.
module srm_core #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [15:0]       out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [1:0] MNone  = 2'b00;
  localparam logic [1:0] MRead  = 2'b01;
  localparam logic [1:0] MWrite = 2'b10;

  typedef enum logic [3:0] {
    StReset, StFetch, StDecode, StLoadA, StLoadB, StExec, StWrite, StAddr, StMem, StHalt
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       ir_q, a_q, b_q, c_q, mdr_q;
  logic [15:0]       rf_q [8];
  logic [ADDR_W-1:0] pc_q, daddr_q;
  logic              n_q, v_q, z_q;

  logic [2:0]        opcode, rn, rd, rm;
  logic [1:0]        op, sh;
  logic [15:0]       sximm8, sh_b, alu_res;
  logic [ADDR_W-1:0] br_off, off5;
  logic              is_movi, is_movr, is_alu, is_cmp, is_ldr, is_str, is_br, is_halt;
  logic              br_taken, sub_ovf;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign br_off = ADDR_W'($signed(ir_q[7:0]));
  assign off5   = ADDR_W'($signed(ir_q[4:0]));

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_ldr  = (opcode == 3'b011);
  assign is_str  = (opcode == 3'b100);
  assign is_br   = (opcode == 3'b001);
  assign is_halt = (opcode == 3'b111);

  always_comb begin
    br_taken = 1'b0;
    unique case (rn)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = z_q;
      3'b010:  br_taken = ~z_q;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    sh_b = b_q;
    unique case (sh)
      2'b00: sh_b = b_q;
      2'b01: sh_b = {b_q[14:0], 1'b0};
      2'b10: sh_b = {1'b0, b_q[15:1]};
      2'b11: sh_b = {b_q[15], b_q[15:1]};
      default: sh_b = b_q;
    endcase
  end

  always_comb begin
    alu_res = sh_b;
    if (is_alu) begin
      unique case (op)
        2'b00: alu_res = a_q + sh_b;
        2'b01: alu_res = a_q - sh_b;
        2'b10: alu_res = a_q & sh_b;
        2'b11: alu_res = ~sh_b;
        default: alu_res = sh_b;
      endcase
    end
  end

  assign sub_ovf = (a_q[15] ^ sh_b[15]) & (alu_res[15] ^ a_q[15]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        if (is_movi)                      state_d = StWrite;
        else if (is_movr)                 state_d = StLoadB;
        else if (is_alu)                  state_d = (op == 2'b11) ? StLoadB : StLoadA;
        else if (is_ldr || is_str)        state_d = StLoadA;
        else if (is_halt)                 state_d = StHalt;
        else                              state_d = StFetch;
      end
      StLoadA:  state_d = (is_ldr || is_str) ? StAddr : StLoadB;
      StLoadB:  state_d = is_str ? StMem : StExec;
      StExec:   state_d = is_cmp ? StFetch : StWrite;
      StWrite:  state_d = StFetch;
      StAddr:   state_d = is_ldr ? StMem : StLoadB;
      StMem:    state_d = mem_ready ? (is_ldr ? StWrite : StFetch) : StMem;
      StHalt:   state_d = StHalt;
      default:  state_d = StReset;
    endcase
  end

  // Output logic
  always_comb begin
    mem_cmd  = MNone;
    mem_addr = pc_q;
    if (state_q == StFetch) begin
      mem_cmd = MRead;
    end else if (state_q == StMem) begin
      mem_cmd  = is_str ? MWrite : MRead;
      mem_addr = daddr_q;
    end
  end

  assign mem_wdata = b_q;
  assign halted    = (state_q == StHalt);
  assign out       = c_q;
  assign N         = n_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign pc        = pc_q;

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mdr_q   <= '0;
      daddr_q <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch:  if (mem_ready) ir_q <= mem_rdata;
        StDecode: pc_q <= pc_q + ADDR_W'(1) + ((is_br && br_taken) ? br_off : '0);
        StLoadA:  a_q <= rf_q[rn];
        StLoadB:  b_q <= is_str ? rf_q[rd] : rf_q[rm];
        StExec: begin
          if (is_cmp) begin
            z_q <= (alu_res == 16'h0000);
            n_q <= alu_res[15];
            v_q <= sub_ovf;
          end else begin
            c_q <= alu_res;
          end
        end
        StAddr:   daddr_q <= a_q[ADDR_W-1:0] + off5;
        StMem:    if (mem_ready && is_ldr) mdr_q <= mem_rdata;
        StWrite: begin
          if (is_movi)     rf_q[rn] <= sximm8;
          else if (is_ldr) rf_q[rd] <= mdr_q;
          else             rf_q[rd] <= c_q;
        end
        default: ;
      endcase
    end
  end

endmodule
